// File: rtl/led_reduce_pkg.sv
// led_reduce_pkg
//   Shared definitions for the LED reduce/stretch driver:
//   - op_sel encodings for the per-channel reduction
//   - cnt_width(): width of a stretch counter able to hold STRETCH
package led_reduce_pkg;

  localparam logic [1:0] OP_OR  = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_NOR = 2'd3;

  // Counter width for a hold of 'stretch' cycles; never narrower than 1 bit
  // so a STRETCH of 0 still yields a legal (if unused) vector type.
  function automatic int cnt_width(input int stretch);
    int w;
    w = $clog2(stretch + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_stretch_cell.sv
// led_stretch_cell
//   One LED channel: reduces GROUP registered input bits with the selected
//   operation, then stretches the result so a single active cycle keeps the
//   LED lit for STRETCH cycles. With STRETCH = 0 the reduction drives the LED
//   directly.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bits   GROUP registered input bits of this channel
//   op     registered reduction op (OP_OR/OP_AND/OP_XOR/OP_NOR)
//   led    stretched channel LED
module led_stretch_cell
  import led_reduce_pkg::*;
#(
  parameter int GROUP   = 2,
  parameter int STRETCH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [GROUP-1:0] bits,
  input  logic [1:0]       op,
  output logic             led
);

  logic red;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    red = 1'b0;
    case (op)
      OP_OR:   red = |bits;
      OP_AND:  red = &bits;
      OP_XOR:  red = ^bits;
      OP_NOR:  red = ~|bits;
      default: red = 1'b0;
    endcase
  end

  if (STRETCH == 0) begin : g_direct
    assign led = red;
  end else begin : g_stretch
    localparam int CW = cnt_width(STRETCH);

    logic [CW-1:0] cnt;

    // Reload on every active cycle (retrigger restarts the hold, it does not
    // extend it); otherwise count down and park at zero.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (red) begin
        cnt <= CW'(STRETCH);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end

    assign led = (cnt != '0);
  end

endmodule

// File: rtl/led_reduce_stretch.sv
// led_reduce_stretch
//   LED driver: registers the input bus and op select, splits the bus into
//   N_CH channels of GROUP bits, reduces and stretches each channel onto one
//   LED, and drives one extra LED from a sticky capture register.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   in       N_CH*GROUP data inputs; channel i = in[i*GROUP +: GROUP]
//   op_sel   reduction op: 0 OR, 1 AND, 2 XOR, 3 NOR
//   cap_clr  synchronous clear of the capture register (wins over capture)
//   o_led    [N_CH-1:0] stretched channel LEDs, [N_CH] capture LED
module led_reduce_stretch
  import led_reduce_pkg::*;
#(
  parameter int N_CH    = 7,
  parameter int GROUP   = 2,
  parameter int STRETCH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*GROUP-1:0] in,
  input  logic [1:0]            op_sel,
  input  logic                  cap_clr,
  output logic [N_CH:0]         o_led
);

  localparam int W = N_CH * GROUP;

  logic [W-1:0]    in_q;
  logic [1:0]      op_q;
  logic            cap_q;
  logic [N_CH-1:0] ch_led;

  // Inputs are synchronous to clk (switches are debounced upstream or the
  // source is fabric logic), so a single register stage is enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= '0;
      op_q <= OP_OR;
    end else begin
      in_q <= in;
      op_q <= op_sel;
    end
  end

  // Capture fires when all of channel 0 is high, whatever the op; it latches
  // the bus MSB and holds it until the next trigger or a clear.
  logic cap_trig;
  assign cap_trig = &in_q[GROUP-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= 1'b0;
    end else if (cap_clr) begin
      cap_q <= 1'b0;
    end else if (cap_trig) begin
      cap_q <= in_q[W-1];
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_stretch_cell #(
      .GROUP   (GROUP),
      .STRETCH (STRETCH)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .bits  (in_q[i*GROUP +: GROUP]),
      .op    (op_q),
      .led   (ch_led[i])
    );
  end

  assign o_led = {cap_q, ch_led};

endmodule

// File: tb/tb_led_reduce_stretch.sv
// tb_led_reduce_stretch
//   Drives a default instance (STRETCH=10) and a STRETCH=0 instance from the
//   same stimulus. A cycle model predicts both LED vectors when stimulus is
//   driven; predictions are queued and compared after the clock edge.
module tb_led_reduce_stretch;

  localparam int N_CH    = 7;
  localparam int GROUP   = 2;
  localparam int STRETCH = 10;
  localparam int W       = N_CH * GROUP;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    in;
  logic [1:0]      op_sel;
  logic            cap_clr;
  logic [N_CH:0]   o_led;
  logic [N_CH:0]   o_led0;

  always #5 clk = ~clk;

  led_reduce_stretch #(.N_CH(N_CH), .GROUP(GROUP), .STRETCH(STRETCH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .op_sel  (op_sel),
    .cap_clr (cap_clr),
    .o_led   (o_led)
  );

  led_reduce_stretch #(.N_CH(N_CH), .GROUP(GROUP), .STRETCH(0)) dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .op_sel  (op_sel),
    .cap_clr (cap_clr),
    .o_led   (o_led0)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N_CH:0] led;
    logic [N_CH:0] led0;
  } exp_t;

  exp_t sb[$];

  // Model state: registered inputs, capture bit, and per channel the number
  // of edges since the reduction was last active (STRETCH means "dark").
  logic [W-1:0]  m_in_q;
  logic [1:0]    m_op_q;
  logic          m_cap;
  int            age [N_CH];
  logic [N_CH:0] last_led;
  logic [N_CH:0] last_led0;

  function automatic logic ch_red(input logic [W-1:0] v, input logic [1:0] op, input int ch);
    int ones;
    ones = 0;
    for (int g = 0; g < GROUP; g++) ones += int'(v[ch*GROUP + g]);
    case (op)
      2'd0:    return ones > 0;
      2'd1:    return ones == GROUP;
      2'd2:    return (ones % 2) == 1;
      default: return ones == 0;
    endcase
  endfunction

  task automatic model_reset();
    m_in_q = '0;
    m_op_q = 2'd0;
    m_cap  = 1'b0;
    for (int i = 0; i < N_CH; i++) age[i] = STRETCH;
  endtask

  // Called just after a rising edge: drive inputs, predict the state after
  // the next edge, then compare once that edge has passed.
  task automatic step(input logic [W-1:0] v, input logic [1:0] op, input logic clr,
                      input string tag);
    exp_t e;
    in      = v;
    op_sel  = op;
    cap_clr = clr;
    for (int i = 0; i < N_CH; i++)
      age[i] = ch_red(m_in_q, m_op_q, i) ? 0 : ((age[i] < STRETCH) ? age[i] + 1 : STRETCH);
    if (clr) m_cap = 1'b0;
    else if (&m_in_q[GROUP-1:0]) m_cap = m_in_q[W-1];
    m_in_q = v;
    m_op_q = op;
    for (int i = 0; i < N_CH; i++) begin
      e.led[i]  = (age[i] < STRETCH);
      e.led0[i] = ch_red(m_in_q, m_op_q, i);
    end
    e.led[N_CH]  = m_cap;
    e.led0[N_CH] = m_cap;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks += 2;
    if (o_led !== e.led) begin
      errors++;
      $display("FAIL %s: o_led=%b expected %b", tag, o_led, e.led);
    end
    if (o_led0 !== e.led0) begin
      errors++;
      $display("FAIL %s (stretch0): o_led=%b expected %b", tag, o_led0, e.led0);
    end
    last_led  = o_led;
    last_led0 = o_led0;
  endtask

  task automatic drain();
    for (int i = 0; i < STRETCH + 2; i++) step('0, 2'd0, 1'b0, "drain");
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    in      = '1;
    op_sel  = 2'd0;
    cap_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 2;
    if (o_led !== '0) begin
      errors++;
      $display("FAIL reset_hold: o_led=%b expected %b", o_led, {(N_CH+1){1'b0}});
    end
    if (o_led0 !== '0) begin
      errors++;
      $display("FAIL reset_hold (stretch0): o_led=%b expected %b", o_led0, {(N_CH+1){1'b0}});
    end
    in    = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step('0, 2'd0, 1'b0, "reset_idle");
  endtask

  task automatic test_single_pulse();
    int hi;
    int first;
    hi    = 0;
    first = -1;
    for (int t = 0; t < STRETCH + 4; t++) begin
      step((t == 0) ? W'(1) : W'(0), 2'd0, 1'b0, "single_pulse");
      if (last_led[0]) begin
        hi++;
        if (first < 0) first = t;
      end
    end
    checks += 2;
    if (first !== 1) begin
      errors++;
      $display("FAIL pulse_latency: first lit step=%0d expected 1", first);
    end
    if (hi !== STRETCH) begin
      errors++;
      $display("FAIL pulse_width: lit cycles=%0d expected %0d", hi, STRETCH);
    end
  endtask

  task automatic test_retrigger();
    int hi;
    hi = 0;
    for (int t = 0; t < 20; t++) begin
      step((t == 0 || t == 5) ? W'(4) : W'(0), 2'd0, 1'b0, "retrigger");
      if (last_led[1]) hi++;
    end
    checks++;
    if (hi !== 15) begin
      errors++;
      $display("FAIL retrigger_width: lit cycles=%0d expected 15", hi);
    end
  endtask

  task automatic test_op_modes();
    logic [3:0] lit_tbl;
    lit_tbl = 4'b0101;  // op 0 OR lit, 1 AND dark, 2 XOR lit, 3 NOR dark for in=01
    for (int op = 0; op < 4; op++) begin
      step(W'(1), 2'(op), 1'b0, "op_mode");
      checks++;
      if (last_led0[0] !== lit_tbl[op]) begin
        errors++;
        $display("FAIL op_mode_direct op=%0d: led0=%b expected %b", op, last_led0[0], lit_tbl[op]);
      end
      step(W'(0), 2'd0, 1'b0, "op_mode");
      checks += 2;
      if (last_led[0] !== lit_tbl[op]) begin
        errors++;
        $display("FAIL op_mode_stretch op=%0d: led0=%b expected %b", op, last_led[0], lit_tbl[op]);
      end
      if (last_led0[0] !== 1'b0) begin
        errors++;
        $display("FAIL op_mode_drop op=%0d: led0=%b expected 0", op, last_led0[0]);
      end
      drain();
    end
    step(W'(0), 2'd3, 1'b0, "nor_zero");
    checks++;
    if (last_led0[0] !== 1'b1) begin
      errors++;
      $display("FAIL nor_zero_direct: led0=%b expected 1", last_led0[0]);
    end
    step(W'(0), 2'd0, 1'b0, "nor_zero");
    checks++;
    if (last_led[0] !== 1'b1) begin
      errors++;
      $display("FAIL nor_zero_stretch: led0=%b expected 1", last_led[0]);
    end
    drain();
  endtask

  task automatic test_capture();
    step(14'h2003, 2'd0, 1'b0, "capture");
    step(14'h2003, 2'd0, 1'b0, "capture");
    checks++;
    if (last_led[N_CH] !== 1'b1) begin
      errors++;
      $display("FAIL capture_set: cap=%b expected 1", last_led[N_CH]);
    end
    step(14'h2001, 2'd0, 1'b0, "capture_hold");
    step(14'h0001, 2'd0, 1'b0, "capture_hold");
    step(14'h2001, 2'd0, 1'b0, "capture_hold");
    step(14'h0001, 2'd0, 1'b0, "capture_hold");
    checks++;
    if (last_led[N_CH] !== 1'b1) begin
      errors++;
      $display("FAIL capture_hold: cap=%b expected 1", last_led[N_CH]);
    end
    step(14'h2003, 2'd0, 1'b0, "capture_clr");
    step(14'h2003, 2'd0, 1'b1, "capture_clr");
    checks++;
    if (last_led[N_CH] !== 1'b0) begin
      errors++;
      $display("FAIL capture_clr_wins: cap=%b expected 0", last_led[N_CH]);
    end
    step(14'h2003, 2'd0, 1'b0, "capture_reset");
    step(14'h0000, 2'd0, 1'b1, "capture_clear");
    drain();
  endtask

  task automatic test_reset_mid_stretch();
    step(W'(1), 2'd0, 1'b0, "mid_reset");
    for (int t = 0; t < 5; t++) step(W'(0), 2'd0, 1'b0, "mid_reset");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks += 2;
    if (o_led !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: o_led=%b expected %b", o_led, {(N_CH+1){1'b0}});
    end
    if (o_led0 !== '0) begin
      errors++;
      $display("FAIL mid_reset_async (stretch0): o_led=%b expected %b", o_led0, {(N_CH+1){1'b0}});
    end
    @(posedge clk);
    #1;
    in    = '0;
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) step(W'(0), 2'd0, 1'b0, "mid_reset_after");
  endtask

  initial begin
    rst_n   = 1'b0;
    in      = '0;
    op_sel  = 2'd0;
    cap_clr = 1'b0;
    test_reset();
    test_single_pulse();
    test_retrigger();
    test_op_modes();
    test_capture();
    test_reset_mid_stretch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
